// File: rtl/adder_rr_sched_pkg.sv
// ----------------------------------------------------------------------------
// adder_rr_sched_pkg
// Shared types and default constants for the round-robin adder scheduler.
//   slot_state_e : occupancy of the single registered result slot
//   *_DEF        : default values for the top-level parameters
// ----------------------------------------------------------------------------
package adder_rr_sched_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 16;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/adder_rr_scheduler16_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Scans last_i+1, last_i+2, ... modulo N
// and picks the first asserted request.
// Ports:
//   req_i   : request vector
//   last_i  : index granted most recently (search starts just after it)
//   en_i    : when low, gnt_o is forced to zero (idx_o/any_o still valid)
//   gnt_o   : one-hot grant, or zero
//   idx_o   : encoded index of the selected request
//   any_o   : at least one request asserted
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] last_i,
  input  logic            en_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  int   cand;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    found = 1'b0;
    // off = N wraps back to last_i itself, so it has lowest priority.
    for (int off = 1; off <= N; off++) begin
      cand = (int'(last_i) + off) % N;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = ID_W'(cand);
      end
    end
    any_o = found;
    if (en_i && found) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/carry_lookahead_adder16.sv
// ----------------------------------------------------------------------------
// carry_lookahead_adder16
// 16-bit two-level carry-lookahead adder: four 4-bit groups with
// group generate/propagate, and a lookahead unit across the groups.
// Ports:
//   a_i, b_i : 16-bit operands
//   cin_i    : carry in
//   sum_o    : 16-bit sum
//   cout_o   : carry out
// ----------------------------------------------------------------------------
module carry_lookahead_adder16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;
  logic [15:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end
  end

  // Group carries in flattened lookahead form, no ripple between groups.
  assign grp_c[0] = cin_i;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin_i);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin_i);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin_i);
  assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin_i);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = grp_c[k];
      c[4*k+1] = g[4*k]   | (p[4*k]   & grp_c[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])   | (p[4*k+1] & p[4*k] & grp_c[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
    end
  end

  assign sum_o  = p ^ c;
  assign cout_o = grp_c[4];

endmodule

// File: rtl/adder_rr_scheduler16.sv
// ----------------------------------------------------------------------------
// adder_rr_scheduler16
// Shares one carry_lookahead_adder16 among NUM_REQ requesters with
// round-robin arbitration. The sum lands in a single registered result slot
// tagged with the requester id. Full slot plus res_ready_i drains and refills
// in the same cycle, giving one operation per cycle.
//
// Optional feature macro: ADDER_RR_SCHED_STATS_EN
//   adds grant_cnt_o, one saturating CNT_W-bit accept counter per requester.
//
// Ports:
//   clk_i        : clock
//   rst_ni       : synchronous active-low reset
//   req_valid_i  : per-requester operand valid
//   req_ready_o  : per-requester accept (one-hot or zero)
//   req_opa_i    : packed operand A, requester k at [k*WIDTH +: WIDTH]
//   req_opb_i    : packed operand B, same packing
//   res_valid_o  : result slot full
//   res_ready_i  : consumer accepts result
//   res_sum_o    : registered {carry, sum}
//   res_id_o     : owner of res_sum_o
//   grant_cnt_o  : (stats build only) packed per-requester accept counters
//
// Slot FSM:
//   state | meaning
//   EMPTY | no result held, any winning request is accepted
//   FULL  | result held on res_*; refill only if res_ready_i drains it
// ----------------------------------------------------------------------------
module adder_rr_scheduler16
  import adder_rr_sched_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int WIDTH   = WIDTH_DEF,
`ifdef ADDER_RR_SCHED_STATS_EN
  parameter  int CNT_W   = CNT_W_DEF,
`endif
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0]   req_opa_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_opb_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [WIDTH:0]             res_sum_o,
  output logic [ID_W-1:0]            res_id_o
`ifdef ADDER_RR_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]   grant_cnt_o
`endif
);

  slot_state_e     state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [WIDTH:0]  sum_q, sum_d;
  logic [ID_W-1:0] id_q, id_d;

  logic            can_accept;
  logic            arb_en;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_any;
  logic            accept;
  logic [WIDTH-1:0] opa_sel;
  logic [WIDTH-1:0] opb_sel;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  assign can_accept = (state_q == EMPTY) || res_ready_i;
  // Gating with rst_ni keeps every ready low while reset is held.
  assign arb_en     = can_accept && rst_ni;
  assign accept     = arb_en && gnt_any;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .en_i   (arb_en),
    .gnt_o  (req_ready_o),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  always_comb begin
    opa_sel = '0;
    opb_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == ID_W'(k)) begin
        opa_sel = req_opa_i[k*WIDTH +: WIDTH];
        opb_sel = req_opb_i[k*WIDTH +: WIDTH];
      end
    end
  end

  carry_lookahead_adder16 u_add (
    .a_i    (opa_sel),
    .b_i    (opb_sel),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sum_d   = sum_q;
    id_d    = id_q;
    if (state_q == FULL && res_ready_i) state_d = EMPTY;
    // An accept overrides the drain above: same-cycle drain-and-refill.
    if (accept) begin
      state_d = FULL;
      sum_d   = {add_cout, add_sum};
      id_d    = gnt_idx;
      last_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      last_q  <= ID_W'(NUM_REQ - 1);
      sum_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
    end
  end

  assign res_valid_o = (state_q == FULL);
  assign res_sum_o   = sum_q;
  assign res_id_o    = id_q;

`ifdef ADDER_RR_SCHED_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (accept && gnt_idx == ID_W'(k) && cnt_q[k] != {CNT_W{1'b1}}) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule
